// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package div_pkg;

  localparam int DIV_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/trial_sub.sv
// Combinational trial subtractor: {borrow, diff} = a - b, built as a + ~b + 1.
module trial_sub #(
  parameter int N = 6
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] diff_o,
  output logic         borrow_o
);

  logic [N:0] sum;

  // A carry out of the top bit means a >= b, so borrow is its inverse.
  assign sum      = {1'b0, a_i} + {1'b0, ~b_i} + {{N{1'b0}}, 1'b1};
  assign diff_o   = sum[N-1:0];
  assign borrow_o = ~sum[N];

endmodule

// File: rtl/seq_divider_5b.sv
// Multi-cycle unsigned restoring divider producing one quotient bit per RUN cycle, MSB first.
module seq_divider_5b
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] dividend_q;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] rem_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] remOut_q;
  logic             divZero_q;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] dividend_d;
  logic             unusedDiffMsb;

  // The partial remainder always stays below the divisor, so WIDTH bits hold it.
  assign trial = {rem_q, dividend_q[WIDTH-1]};

  trial_sub #(.N(WIDTH + 1)) u_trial_sub (
    .a_i      (trial),
    .b_i      ({1'b0, divisor_q}),
    .diff_o   (diff),
    .borrow_o (borrow)
  );

  assign unusedDiffMsb = diff[WIDTH];
  assign rem_d         = borrow ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
  assign dividend_d    = {dividend_q[WIDTH-2:0], ~borrow};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      quot_q     <= '0;
      remOut_q   <= '0;
      divZero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            busy_q <= 1'b1;
            if (y != '0) begin
              state_q    <= RUN;
              dividend_q <= x;
              divisor_q  <= y;
              rem_q      <= '0;
              cnt_q      <= CW'(WIDTH - 1);
            end else begin
              state_q   <= DONE;
              done_q    <= 1'b1;
              quot_q    <= '1;
              remOut_q  <= x;
              divZero_q <= 1'b1;
            end
          end
        end
        RUN: begin
          dividend_q <= dividend_d;
          rem_q      <= rem_d;
          cnt_q      <= cnt_q - CW'(1);
          // The dividend register has become the quotient once the last bit shifts in.
          if (cnt_q == '0) begin
            state_q   <= DONE;
            done_q    <= 1'b1;
            quot_q    <= dividend_d;
            remOut_q  <= rem_d;
            divZero_q <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign q           = quot_q;
  assign r           = remOut_q;
  assign div_by_zero = divZero_q;

endmodule

// File: tb/tb_seq_divider_5b.sv
// Scoreboard bench for seq_divider_5b: stimulus queues expected results, a monitor checks each done pulse.
module tb_seq_divider_5b;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [4:0] x;
  logic [4:0] y;
  logic       busy;
  logic       done;
  logic [4:0] q;
  logic [4:0] r;
  logic       div_by_zero;

  typedef struct packed {
    logic [4:0] q;
    logic [4:0] r;
    logic       dz;
  } exp_t;

  exp_t expQueue[$];
  int   vectors     = 0;
  int   miscompares = 0;

  seq_divider_5b dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .x           (x),
    .y           (y),
    .busy        (busy),
    .done        (done),
    .q           (q),
    .r           (r),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int required);
    vectors++;
    if (actual != required) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
    end
  endtask

  // Monitor: every done pulse must consume exactly one queued expectation.
  always @(negedge clk) begin
    if (done) begin
      if (expQueue.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpectedDone: got done with q=%0d r=%0d, expected no pulse", q, r);
      end else begin
        exp_t e;
        e = expQueue.pop_front();
        checkOutput("quotient", q, e.q);
        checkOutput("remainder", r, e.r);
        checkOutput("divByZero", div_by_zero, e.dz);
      end
    end
  end

  task automatic applyStimulus(input logic [4:0] ax, input logic [4:0] ay,
                               input logic [4:0] eq, input logic [4:0] er,
                               input logic edz, input int injectAt);
    exp_t e;
    int   cyc;
    int   busyCnt;
    bit   seen;
    int   expLat;
    e.q  = eq;
    e.r  = er;
    e.dz = edz;
    expQueue.push_back(e);
    expLat = (ay == 5'd0) ? 1 : 6;
    x     = ax;
    y     = ay;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x     = ~ax;
    y     = ~ay;
    cyc     = 1;
    busyCnt = 0;
    seen    = 0;
    while (cyc <= 20) begin
      if (busy) busyCnt++;
      if (done) begin
        seen = 1;
        break;
      end
      if (cyc == injectAt) begin
        start = 1'b1;
        x     = 5'd9;
        y     = 5'd2;
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL doneTimeout: got no done within 20 cycles for x=%0d y=%0d, expected done", ax, ay);
    end else begin
      checkOutput("latency", cyc, expLat);
      checkOutput("busyCycles", busyCnt, expLat);
    end
    @(negedge clk);
    checkOutput("doneSinglePulse", done, 0);
    checkOutput("busyAfterDone", busy, 0);
    checkOutput("quotientHeld", q, eq);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    x     = '0;
    y     = '0;
    repeat (2) @(negedge clk);
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetDone", done, 0);
    checkOutput("resetQ", q, 0);
    checkOutput("resetR", r, 0);
    checkOutput("resetDz", div_by_zero, 0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(5'd23, 5'd5, 5'd4, 5'd3, 1'b0, 0);
    applyStimulus(5'd31, 5'd1, 5'd31, 5'd0, 1'b0, 0);
    applyStimulus(5'd3, 5'd9, 5'd0, 5'd3, 1'b0, 0);
    applyStimulus(5'd7, 5'd0, 5'd31, 5'd7, 1'b1, 0);
    applyStimulus(5'd10, 5'd3, 5'd3, 5'd1, 1'b0, 0);
    applyStimulus(5'd20, 5'd4, 5'd5, 5'd0, 1'b0, 2);

    // Abort a division in its third RUN cycle; no done may follow.
    x     = 5'd29;
    y     = 5'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortDone", done, 0);
    checkOutput("abortQ", q, 0);
    checkOutput("abortR", r, 0);
    checkOutput("abortDz", div_by_zero, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    applyStimulus(5'd29, 5'd3, 5'd9, 5'd2, 1'b0, 0);

    for (int xi = 0; xi < 32; xi++) begin
      for (int yi = 0; yi < 32; yi++) begin
        if (yi == 0)
          applyStimulus(5'(xi), 5'd0, 5'd31, 5'(xi), 1'b1, 0);
        else
          applyStimulus(5'(xi), 5'(yi), 5'(xi / yi), 5'(xi % yi), 1'b0, 0);
      end
    end

    repeat (3) @(negedge clk);
    checkOutput("queueDrained", expQueue.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
